axil_regfile_s: RTL and testbench
=================================

# axil_regfile_s

AXI4-Lite slave register file that sits directly downstream of the `axis_lite_m` master and terminates its `m_axi_*` channels. It decodes word addresses inside a configurable window and applies byte-strobed writes to a bank of 32-bit registers. It returns OKAY/SLVERR responses and exposes every register, plus per-register write pulses, to user logic. The AW, W and B channels run one FSM and the AR and R channels run another; the two are independent.

## Interface
Parameters:
- `NUM_REGS`, 16: number of 32-bit registers; power of two, 2..256.
- `BASE_ADDR`, 32'hAAAA_BB80: window base; bits below `IDX_W+2` must be 0.
- `RESET_VAL`, 32'h0000_0000: reset value of every register.

Ports (`IDX_W = $clog2(NUM_REGS)`):
- `aclk` in 1: single clock; all logic on rising edge.
- `areset` in 1: reset, synchronous and active-high.
- `s_axi_awaddr` in 32, `s_axi_awprot` in 3 (ignored), `s_axi_awvalid` in 1, `s_axi_awready` out 1.
- `s_axi_wdata` in 32, `s_axi_wstrb` in 4, `s_axi_wvalid` in 1, `s_axi_wready` out 1.
- `s_axi_bresp` out 2, `s_axi_bvalid` out 1, `s_axi_bready` in 1.
- `s_axi_araddr` in 32, `s_axi_arprot` in 3 (ignored), `s_axi_arvalid` in 1, `s_axi_arready` out 1.
- `s_axi_rdata` out 32, `s_axi_rresp` out 2, `s_axi_rvalid` out 1, `s_axi_rready` in 1.
- `reg_q` out `NUM_REGS*32`: register contents, with reg i at bits [32i+31:32i].
- `reg_wr_pulse` out `NUM_REGS`: one-cycle pulse on the cycle after a register is committed.

## Operation
- Decode:
  - The address hits when `addr[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]`.
  - The index is `addr[IDX_W+1:2]`.
  - `addr[1:0]` is ignored.
- Write FSM states:
  - **W_IDLE**: `awready` and `wready` are both 1. The AW and W handshakes are captured independently, in either order or in the same cycle. Each ready drops to 0 on the edge its own handshake completes. The FSM leaves on the edge where the second of the two handshakes completes and goes to W_RESP. That edge is the commit edge.
  - **W_RESP**: `bvalid` is 1 and both readies are 0. `bvalid` is held until `bready`. On `bvalid && bready` the FSM returns to W_IDLE, and both readies are 1 on the next cycle.
- Commit on a hit:
  - For each byte b with `wstrb[b]` set, `reg[idx][8b+7:8b] <= wdata[8b+7:8b]`.
  - `bresp` = OKAY (2'b00).
  - `reg_wr_pulse[idx]` = 1 for the following cycle, even when wstrb = 0.
- Commit on a miss: no register changes, no pulse, `bresp` = SLVERR (2'b10).
- Read FSM states:
  - **R_IDLE**: `arready` = 1. On the AR handshake, `rdata` and `rresp` are registered and the FSM goes to R_RESP.
  - **R_RESP**: `rvalid` = 1 and `arready` = 0. Held until `rready`, then the FSM returns to R_IDLE.
- Read data:
  - On a hit, `rdata` is the register value before the handshake edge and `rresp` = OKAY.
  - On a miss, `rdata` = 0 and `rresp` = SLVERR.
- A write committing on the same edge as a read's AR handshake is not visible to that read.

## Timing
- During reset, all outputs are 0, including readies, `bresp`, `rresp`, `rdata` and `reg_wr_pulse`. `reg_q` = RESET_VAL.
- The first cycle after `areset` falls has `awready`, `wready` and `arready` = 1.
- Write latency: `bvalid` rises 1 cycle after the last AW/W handshake. Register update and `reg_q` change on the same edge.
- Read latency: `rvalid` rises 1 cycle after the AR handshake.
- Maximum throughput is one write per 2 cycles and, concurrently, one read per 2 cycles when bready/rready are held at 1.
- `bresp` and `rdata`/`rresp` are stable while their valid is high.
- Reset mid-transaction: captured-but-uncommitted AW or W is discarded. Any pending B or R is dropped. Registers take RESET_VAL even if a commit coincides with the reset edge, because reset has priority.

## Structure
- Shared package `axil_pkg` holds:
  - `RESP_OKAY` = 2'b00 and `RESP_SLVERR` = 2'b10.
  - Enum `wr_state_t` {W_IDLE, W_RESP}.
  - Enum `rd_state_t` {R_IDLE, R_RESP}.
- Sub-module `axil_reg_bank` holds the storage array, byte-strobe merge, write pulse and read mux. The top level holds the decode and both FSMs.

## Test plan
- Reset: hold `areset` high for 5 cycles -> all outputs 0, `reg_q` all 0. Readies are 1 in the first cycle after release.
- `axis_lite_m` writes awaddr 0xAAAA_BBBB and wdata 0x5AA5_A55A with wstrb F, AW and W in the same cycle -> `bvalid` the next cycle with bresp 00. reg[14] = 0x5AA5_A55A and `reg_wr_pulse[14]` pulses once. A read of 0xAAAA_BBB8 returns 0x5AA5_A55A with rresp 00.
- W handshake 3 cycles before AW, with `bready` held low 4 cycles after `bvalid` -> `wready` is 0 after the W handshake. Commit happens only on the AW edge. `bvalid` is held and no new AW/W is accepted until `bready`.
- reg[14] = 0x5AA5_A55A, write 0x1122_3344 with wstrb 4'b0101 -> reg[14] = 0x5A22_A544.
- Write to 0x0000_0010 -> bresp 10, no register change, no pulse. A read of 0x0000_0010 returns rdata 0 with rresp 10.
- Write committing to reg[3] on the same edge as an AR handshake to reg[3] -> that read returns the old value. The next read returns the new value.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and FSM state types for the register-file slave.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

endpackage

// File: rtl/axil_reg_bank.sv
// Register storage with byte-strobed writes, one-cycle write pulses and a combinational read mux.
module axil_reg_bank #(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned IDX_W     = 4,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [IDX_W-1:0]         i_widx,
  input  logic [31:0]              i_wdata,
  input  logic [3:0]               i_wstrb,
  input  logic [IDX_W-1:0]         i_ridx,
  output logic [31:0]              o_rdata,
  output logic [NUM_REGS*32-1:0]   o_reg_q,
  output logic [NUM_REGS-1:0]      o_wr_pulse
);

  logic [NUM_REGS-1:0][31:0] r_regs;
  logic [NUM_REGS-1:0]       r_pulse;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
      r_pulse <= '0;
    end else begin
      r_pulse <= '0;
      if (i_we) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (i_wstrb[b]) begin
            r_regs[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
        // Pulse fires on every committed hit, including an all-zero strobe.
        r_pulse[i_widx] <= 1'b1;
      end
    end
  end

  assign o_rdata    = r_regs[i_ridx];
  assign o_reg_q    = r_regs;
  assign o_wr_pulse = r_pulse;

endmodule

// File: rtl/axil_regfile_s.sv
// AXI4-Lite slave register file: address decode plus independent write (AW/W/B) and read (AR/R) FSMs.
module axil_regfile_s
  import axil_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'hAAAA_BB80,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [31:0]            s_axi_awaddr,
  input  logic [2:0]             s_axi_awprot,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [31:0]            s_axi_wdata,
  input  logic [3:0]             s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [31:0]            s_axi_araddr,
  input  logic [2:0]             s_axi_arprot,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [31:0]            s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic [NUM_REGS*32-1:0] reg_q,
  output logic [NUM_REGS-1:0]    reg_wr_pulse
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  function automatic logic addr_hit(input logic [31:0] a);
    return a[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2];
  endfunction

  wr_state_t   r_wstate, w_wstate_nxt;
  rd_state_t   r_rstate, w_rstate_nxt;
  logic        r_aw_done, r_w_done;
  logic [31:0] r_awaddr, r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_bresp, r_rresp;
  logic [31:0] r_rdata;

  logic        w_awready, w_wready, w_arready;
  logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_hit, w_rd_hit;
  logic [31:0] w_cm_addr, w_cm_data, w_bank_rdata;
  logic [3:0]  w_cm_strb;

  // Readies are gated by reset so they read 0 for the whole reset window.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = !areset && !r_aw_done;
        w_wready  = !areset && !r_w_done;
        if (w_commit) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        if (s_axi_bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  assign w_aw_hs   = s_axi_awvalid && w_awready;
  assign w_w_hs    = s_axi_wvalid && w_wready;
  assign w_commit  = (r_wstate == W_IDLE) && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
  // Whichever half arrives on the commit edge is taken straight from the bus.
  assign w_cm_addr = w_aw_hs ? s_axi_awaddr : r_awaddr;
  assign w_cm_data = w_w_hs ? s_axi_wdata : r_wdata;
  assign w_cm_strb = w_w_hs ? s_axi_wstrb : r_wstrb;
  assign w_wr_hit  = addr_hit(w_cm_addr);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wstate  <= W_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_commit) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_bresp   <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (w_aw_hs) begin
          r_aw_done <= 1'b1;
          r_awaddr  <= s_axi_awaddr;
        end
        if (w_w_hs) begin
          r_w_done <= 1'b1;
          r_wdata  <= s_axi_wdata;
          r_wstrb  <= s_axi_wstrb;
        end
      end
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_arready    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_arready = !areset;
        if (s_axi_arvalid && w_arready) w_rstate_nxt = R_RESP;
      end
      R_RESP: begin
        if (s_axi_rready) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign w_ar_hs  = s_axi_arvalid && w_arready;
  assign w_rd_hit = addr_hit(s_axi_araddr);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_rdata <= w_rd_hit ? w_bank_rdata : '0;
        r_rresp <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  axil_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .i_clk      (aclk),
    .i_rst      (areset),
    .i_we       (w_commit && w_wr_hit),
    .i_widx     (w_cm_addr[IDX_W+1:2]),
    .i_wdata    (w_cm_data),
    .i_wstrb    (w_cm_strb),
    .i_ridx     (s_axi_araddr[IDX_W+1:2]),
    .o_rdata    (w_bank_rdata),
    .o_reg_q    (reg_q),
    .o_wr_pulse (reg_wr_pulse)
  );

  assign s_axi_awready = w_awready;
  assign s_axi_wready  = w_wready;
  assign s_axi_arready = w_arready;
  assign s_axi_bvalid  = (r_wstate == W_RESP);
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = (r_rstate == R_RESP);
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;

  logic w_unused;
  assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_araddr[1:0], r_awaddr[1:0]};

endmodule

// File: tb/tb_axil_regfile_s.sv
// Bench for axil_regfile_s: directed and randomized AXI4-Lite traffic against an array-based register model.
module tb_axil_regfile_s;

  localparam int unsigned NR   = 16;
  localparam logic [31:0] BASE = 32'hAAAA_BB80;

  logic           aclk = 1'b0;
  logic           areset = 1'b1;
  logic [31:0]    s_axi_awaddr = '0;
  logic [2:0]     s_axi_awprot = '0;
  logic           s_axi_awvalid = 1'b0;
  logic           s_axi_awready;
  logic [31:0]    s_axi_wdata = '0;
  logic [3:0]     s_axi_wstrb = '0;
  logic           s_axi_wvalid = 1'b0;
  logic           s_axi_wready;
  logic [1:0]     s_axi_bresp;
  logic           s_axi_bvalid;
  logic           s_axi_bready = 1'b0;
  logic [31:0]    s_axi_araddr = '0;
  logic [2:0]     s_axi_arprot = '0;
  logic           s_axi_arvalid = 1'b0;
  logic           s_axi_arready;
  logic [31:0]    s_axi_rdata;
  logic [1:0]     s_axi_rresp;
  logic           s_axi_rvalid;
  logic           s_axi_rready = 1'b0;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0]  reg_wr_pulse;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [NR];

  always #5 aclk = ~aclk;

  axil_regfile_s #(
    .NUM_REGS  (NR),
    .BASE_ADDR (BASE),
    .RESET_VAL (32'h0000_0000)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .reg_q         (reg_q),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  // Window is 16 words of 4 bytes, so everything above bit 5 must match the base.
  function automatic bit m_hit(input logic [31:0] a);
    return (a >> 6) == (BASE >> 6);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % NR);
  endfunction

  function automatic logic [NR*32-1:0] m_q();
    logic [NR*32-1:0] q;
    for (int i = 0; i < NR; i++) q[32*i +: 32] = mdl[i];
    return q;
  endfunction

  task automatic test_reset();
    areset = 1'b1;
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 00000",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid});
    end
    checks++;
    if ({s_axi_bresp, s_axi_rresp, s_axi_rdata, reg_wr_pulse} !== '0) begin
      errors++;
      $display("FAIL reset_data got bresp=%b rresp=%b rdata=%h pulse=%h want 0",
               s_axi_bresp, s_axi_rresp, s_axi_rdata, reg_wr_pulse);
    end
    checks++;
    if (reg_q !== '0) begin errors++; $display("FAIL reset_regq got %h want 0", reg_q); end
    @(posedge aclk); #1;
    areset = 1'b0;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    @(negedge aclk);
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0, idx;
    logic [1:0] exp_resp;
    logic [NR-1:0] exp_pulse = '0;
    if (m_hit(addr)) begin
      idx = m_idx(addr);
      for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
      exp_pulse[idx] = 1'b1;
      exp_resp = 2'b00;
    end else begin
      exp_resp = 2'b10;
    end
    @(posedge aclk); #1;
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    while (!(aw_done && w_done) && cyc < 64) begin
      s_axi_awvalid = !aw_done && cyc >= aw_dly;
      s_axi_wvalid  = !w_done && cyc >= w_dly;
      @(negedge aclk);
      checks++;
      if (s_axi_bvalid !== 1'b0) begin errors++; $display("FAIL wr_early_bvalid got %b want 0", s_axi_bvalid); end
      if (aw_done) begin
        checks++;
        if (s_axi_awready !== 1'b0) begin errors++; $display("FAIL wr_awready_drop got %b want 0", s_axi_awready); end
      end
      if (w_done) begin
        checks++;
        if (s_axi_wready !== 1'b0) begin errors++; $display("FAIL wr_wready_drop got %b want 0", s_axi_wready); end
      end
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge aclk); #1;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      cyc++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      checks++; errors++;
      $display("FAIL wr_timeout got aw=%0d w=%0d want both handshakes", aw_done, w_done);
      return;
    end
    @(negedge aclk);
    checks++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== exp_resp) begin
      errors++;
      $display("FAIL wr_resp got bvalid=%b bresp=%b want 1/%b", s_axi_bvalid, s_axi_bresp, exp_resp);
    end
    checks++;
    if (reg_wr_pulse !== exp_pulse) begin errors++; $display("FAIL wr_pulse got %h want %h", reg_wr_pulse, exp_pulse); end
    checks++;
    if (reg_q !== m_q()) begin errors++; $display("FAIL wr_regq got %h want %h", reg_q, m_q()); end
    repeat (b_dly) begin
      @(posedge aclk);
      @(negedge aclk);
      checks++;
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== exp_resp || s_axi_awready !== 1'b0 ||
          s_axi_wready !== 1'b0 || reg_wr_pulse !== '0) begin
        errors++;
        $display("FAIL wr_bhold got bvalid=%b bresp=%b awr=%b wr=%b pulse=%h want 1/%b/0/0/0",
                 s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready, reg_wr_pulse, exp_resp);
      end
    end
    s_axi_bready = 1'b1;
    @(posedge aclk); #1;
    s_axi_bready = 1'b0;
    @(negedge aclk);
    checks++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1 || reg_wr_pulse !== '0) begin
      errors++;
      $display("FAIL wr_done got bvalid=%b awr=%b wr=%b pulse=%h want 0/1/1/0",
               s_axi_bvalid, s_axi_awready, s_axi_wready, reg_wr_pulse);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
    bit done = 0, hs;
    int cyc = 0;
    logic [31:0] exp_data;
    logic [1:0] exp_resp;
    exp_data = m_hit(addr) ? mdl[m_idx(addr)] : 32'h0;
    exp_resp = m_hit(addr) ? 2'b00 : 2'b10;
    @(posedge aclk); #1;
    s_axi_araddr = addr;
    while (!done && cyc < 64) begin
      s_axi_arvalid = cyc >= ar_dly;
      @(negedge aclk);
      checks++;
      if (s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid got %b want 0", s_axi_rvalid); end
      hs = s_axi_arvalid && s_axi_arready;
      @(posedge aclk); #1;
      if (hs) done = 1;
      cyc++;
    end
    s_axi_arvalid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL rd_timeout got no AR handshake want handshake");
      return;
    end
    for (int k = 0; k <= r_dly; k++) begin
      @(negedge aclk);
      checks++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== exp_data || s_axi_rresp !== exp_resp || s_axi_arready !== 1'b0) begin
        errors++;
        $display("FAIL rd_data got rvalid=%b rdata=%h rresp=%b arr=%b want 1/%h/%b/0",
                 s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_arready, exp_data, exp_resp);
      end
      if (k < r_dly) @(posedge aclk);
    end
    s_axi_rready = 1'b1;
    @(posedge aclk); #1;
    s_axi_rready = 1'b0;
    @(negedge aclk);
    checks++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL rd_done got rvalid=%b arr=%b want 0/1", s_axi_rvalid, s_axi_arready);
    end
  endtask

  task automatic test_basic();
    do_write(32'hAAAA_BBBB, 32'h5AA5_A55A, 4'hF, 0, 0, 0);
    do_read(32'hAAAA_BBB8, 0, 0);
  endtask

  task automatic test_w_before_aw();
    do_write(32'hAAAA_BB84, 32'hCAFE_F00D, 4'hF, 3, 0, 4);
    do_read(32'hAAAA_BB84, 1, 2);
  endtask

  task automatic test_strobe();
    do_write(32'hAAAA_BBB8, 32'h1122_3344, 4'b0101, 0, 1, 0);
    checks++;
    if (reg_q[14*32 +: 32] !== 32'h5A22_A544) begin
      errors++;
      $display("FAIL strobe_merge got %h want 5a22a544", reg_q[14*32 +: 32]);
    end
    do_write(32'hAAAA_BBB8, 32'hFFFF_FFFF, 4'b0000, 0, 0, 1);
  endtask

  task automatic test_miss();
    do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_read(32'h0000_0010, 0, 0);
  endtask

  task automatic test_same_edge();
    logic [31:0] old_v, new_v;
    old_v = mdl[3];
    new_v = ~old_v ^ $urandom;
    @(posedge aclk); #1;
    s_axi_awaddr = BASE + 32'd12; s_axi_wdata = new_v; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_araddr = BASE + 32'd12; s_axi_arvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    mdl[3] = new_v;
    @(negedge aclk);
    checks++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== old_v || s_axi_rresp !== 2'b00) begin
      errors++;
      $display("FAIL same_edge_read got rvalid=%b rdata=%h rresp=%b want 1/%h/00",
               s_axi_rvalid, s_axi_rdata, s_axi_rresp, old_v);
    end
    checks++;
    if (s_axi_bvalid !== 1'b1 || reg_q[3*32 +: 32] !== new_v) begin
      errors++;
      $display("FAIL same_edge_write got bvalid=%b reg3=%h want 1/%h", s_axi_bvalid, reg_q[3*32 +: 32], new_v);
    end
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(posedge aclk); #1;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    do_read(BASE + 32'd12, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) != 0)
        addr = BASE | (32'($urandom_range(0, NR - 1)) << 2) | 32'($urandom_range(0, 3));
      else
        addr = BASE ^ (32'h1 << $urandom_range(31, 6));
      if ($urandom_range(0, 1) == 1)
        do_write(addr, $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      else
        do_read(addr, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_mid_reset();
    @(posedge aclk); #1;
    s_axi_wdata = 32'h7777_7777; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi_wvalid = 1'b0;
    areset = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++;
    if (reg_q !== '0 || s_axi_wready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got regq=%h wready=%b want 0/0", reg_q, s_axi_wready);
    end
    @(posedge aclk); #1;
    areset = 1'b0;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    @(negedge aclk);
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b110) begin
      errors++;
      $display("FAIL midreset_release got %b want 110", {s_axi_awready, s_axi_wready, s_axi_bvalid});
    end
    do_write(BASE + 32'd20, 32'h0000_00A5, 4'b0001, 0, 2, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_w_before_aw();
    test_strobe();
    test_miss();
    test_same_edge();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
